pair_sequencer: RTL and testbench

PAIR_SEQUENCER -- requirements
Module: pair_sequencer

---
 rtl/pair_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_pair_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pair_sequencer.sv
// All-pairs (i,j) issue sequencer for an N-body acceleration pipeline, with a matching tag delay line.
// Build option: define PAIR_SKIP_SELF_EN to drop i==j pairs from the sweep.
module pair_sequencer #(
  parameter int BODIES          = 512,
  parameter int BODY_ADDR_WIDTH = $clog2(BODIES),
  parameter int PIPE_DEPTH      = 124
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [BODY_ADDR_WIDTH:0]   num_bodies,
  output logic [BODY_ADDR_WIDTH-1:0] rd_i,
  output logic [BODY_ADDR_WIDTH-1:0] rd_j,
  output logic                       issue_valid,
  output logic [BODY_ADDR_WIDTH-1:0] tag_i,
  output logic [BODY_ADDR_WIDTH-1:0] tag_j,
  output logic                       tag_valid,
  output logic                       tag_first,
  output logic                       tag_last,
  output logic                       tag_self,
  output logic                       busy,
  output logic                       done
);

  localparam int          AW    = BODY_ADDR_WIDTH;
  localparam int unsigned DEPTH = PIPE_DEPTH;

`ifdef PAIR_SKIP_SELF_EN
  localparam logic SKIP_SELF = 1'b1;
`else
  localparam logic SKIP_SELF = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] i;
    logic [AW-1:0] j;
    logic          first;
    logic          last;
    logic          self_pair;
    logic          final_pair;
  } tag_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW:0]   n_lat;
  logic [AW:0]   n_nxt;
  logic [AW-1:0] i_nxt;
  logic [AW-1:0] j_nxt;
  logic          iv_nxt;
  logic          done_zero_nxt;
  logic          done_q;

  logic [AW:0]   n_clamp;
  logic [AW:0]   i_ext;
  logic [AW:0]   j_ext;
  logic [AW:0]   j_inc;
  logic [AW:0]   j_step;
  logic          row_end;
  logic          sweep_end;
  logic          no_pairs;

  tag_t          pipe [DEPTH];
  tag_t          pipe_in;
  tag_t          last_in;

  assign n_clamp  = (num_bodies > (AW+1)'(BODIES)) ? (AW+1)'(BODIES) : num_bodies;
  assign no_pairs = (n_clamp == '0) || (SKIP_SELF && (n_clamp == (AW+1)'(1)));

  // rd_i/rd_j double as the pair counters; the successor pair is derived from them.
  assign i_ext     = {1'b0, rd_i};
  assign j_ext     = {1'b0, rd_j};
  assign j_inc     = j_ext + 1'b1;
  assign j_step    = (SKIP_SELF && (j_inc == i_ext)) ? j_inc + 1'b1 : j_inc;
  assign row_end   = (j_step >= n_lat);
  assign sweep_end = row_end && ((i_ext + 1'b1) >= n_lat);

  always_comb begin
    pipe_in = '0;
    if (issue_valid) begin
      pipe_in.valid      = 1'b1;
      pipe_in.i          = rd_i;
      pipe_in.j          = rd_j;
      // Skipping self pairs moves the first pair of row 0 to j==1.
      pipe_in.first      = ((rd_j == '0) && !(SKIP_SELF && (rd_i == '0))) ||
                           (SKIP_SELF && (rd_i == '0) && (rd_j == AW'(1)));
      pipe_in.last       = row_end;
      pipe_in.self_pair  = !SKIP_SELF && (rd_i == rd_j);
      pipe_in.final_pair = sweep_end;
    end
  end

  always_comb begin
    state_nxt     = state;
    n_nxt         = n_lat;
    i_nxt         = rd_i;
    j_nxt         = rd_j;
    iv_nxt        = 1'b0;
    done_zero_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          n_nxt = n_clamp;
          i_nxt = '0;
          j_nxt = '0;
          if (no_pairs) begin
            done_zero_nxt = 1'b1;
          end else begin
            state_nxt = ISSUE;
            iv_nxt    = 1'b1;
            j_nxt     = SKIP_SELF ? AW'(1) : '0;
          end
        end
      end
      ISSUE: begin
        if (sweep_end) begin
          state_nxt = DRAIN;
          i_nxt     = '0;
          j_nxt     = '0;
        end else begin
          iv_nxt = 1'b1;
          if (row_end) begin
            i_nxt = rd_i + 1'b1;
            j_nxt = '0;
          end else begin
            j_nxt = j_step[AW-1:0];
          end
        end
      end
      DRAIN: begin
        if (pipe[DEPTH-1].valid && pipe[DEPTH-1].final_pair) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt     = IDLE;
      iv_nxt        = 1'b0;
      i_nxt         = '0;
      j_nxt         = '0;
      done_zero_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      n_lat       <= '0;
      rd_i        <= '0;
      rd_j        <= '0;
      issue_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      n_lat       <= n_nxt;
      rd_i        <= i_nxt;
      rd_j        <= j_nxt;
      issue_valid <= iv_nxt;
    end
  end

  if (PIPE_DEPTH > 1) begin : g_last_in
    assign last_in = pipe[DEPTH-2];
  end else begin : g_last_in_direct
    assign last_in = pipe_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) pipe[k] <= '0;
    end else if (abort) begin
      for (int unsigned k = 0; k < DEPTH; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= pipe_in;
      for (int unsigned k = 1; k < DEPTH; k++) pipe[k] <= pipe[k-1];
    end
  end

  // done is registered from the entry about to reach the last stage so it lines up with the final tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_zero_nxt || (!abort && last_in.valid && last_in.final_pair);
    end
  end

  assign tag_valid = pipe[DEPTH-1].valid;
  assign tag_i     = pipe[DEPTH-1].i;
  assign tag_j     = pipe[DEPTH-1].j;
  assign tag_first = pipe[DEPTH-1].first;
  assign tag_last  = pipe[DEPTH-1].last;
  assign tag_self  = pipe[DEPTH-1].self_pair;
  assign busy      = (state != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_pair_sequencer.sv
// Directed bench for pair_sequencer; expectations follow PAIR_SKIP_SELF_EN when it is defined.
module tb_pair_sequencer;

  localparam int BODIES = 16;
  localparam int AW     = 4;
  localparam int DEPTH  = 124;

`ifdef PAIR_SKIP_SELF_EN
  localparam bit SKIP = 1'b1;
  localparam int N3P  = 6;
  int n3 [N3P][5] = '{'{0,1,1,0,0}, '{0,2,0,1,0}, '{1,0,1,0,0},
                      '{1,2,0,1,0}, '{2,0,1,0,0}, '{2,1,0,1,0}};
`else
  localparam bit SKIP = 1'b0;
  localparam int N3P  = 9;
  int n3 [N3P][5] = '{'{0,0,1,0,1}, '{0,1,0,0,0}, '{0,2,0,1,0},
                      '{1,0,1,0,0}, '{1,1,0,0,1}, '{1,2,0,1,0},
                      '{2,0,1,0,0}, '{2,1,0,0,0}, '{2,2,0,1,1}};
`endif

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [AW:0]   num_bodies;
  logic [AW-1:0] rd_i, rd_j, tag_i, tag_j;
  logic          issue_valid, tag_valid, tag_first, tag_last, tag_self, busy, done;

  always #5 clk = ~clk;

  pair_sequencer #(.BODIES(BODIES), .BODY_ADDR_WIDTH(AW), .PIPE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_bodies(num_bodies),
    .rd_i(rd_i), .rd_j(rd_j), .issue_valid(issue_valid),
    .tag_i(tag_i), .tag_j(tag_j), .tag_valid(tag_valid), .tag_first(tag_first),
    .tag_last(tag_last), .tag_self(tag_self), .busy(busy), .done(done)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int tcode(input int i, input int j, input int f, input int l, input int s);
    return i * 4096 + j * 16 + f * 4 + l * 2 + s;
  endfunction

  int iss_q[$];
  int tag_q[$];
  int done_cnt, done_cyc, done_tag, first_iss_cyc, first_tag_cyc;
  int busy_at_done, busy_after_done, busy_after_abort, iv_after_abort;

  // Starts a sweep of n bodies and records everything seen at negedges until done settles or max_cyc.
  task automatic run(input int n, input int abort_at, input int restart_at, input int max_cyc);
    int cyc = 0;
    int nis = 0;
    int abort_cyc = -10;
    iss_q.delete();
    tag_q.delete();
    done_cnt = 0; done_cyc = -1; done_tag = -1; first_iss_cyc = -1; first_tag_cyc = -1;
    busy_at_done = -1; busy_after_done = -1; busy_after_abort = -1; iv_after_abort = -1;
    @(negedge clk);
    num_bodies = (AW+1)'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < max_cyc && !(done_cnt > 0 && cyc > done_cyc + 2)) begin
      if (issue_valid) begin
        iss_q.push_back(int'(rd_i) * 256 + int'(rd_j));
        nis++;
        if (first_iss_cyc < 0) first_iss_cyc = cyc;
      end
      if (tag_valid) begin
        tag_q.push_back(tcode(int'(tag_i), int'(tag_j), int'(tag_first), int'(tag_last), int'(tag_self)));
        if (first_tag_cyc < 0) first_tag_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        done_tag = tag_valid ? tcode(int'(tag_i), int'(tag_j), int'(tag_first), int'(tag_last), int'(tag_self)) : -1;
        busy_at_done = int'(busy);
      end
      if (done_cnt > 0 && cyc == done_cyc + 1) busy_after_done = int'(busy);
      if (cyc == abort_cyc + 1) begin
        busy_after_abort = int'(busy);
        iv_after_abort   = int'(issue_valid);
      end
      abort = 1'b0;
      start = 1'b0;
      if (issue_valid && nis == abort_at) begin
        abort = 1'b1;
        abort_cyc = cyc;
      end
      if (issue_valid && nis == restart_at) start = 1'b1;
      @(negedge clk);
      cyc++;
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  task automatic check_n3(input string pfx);
    check({pfx, "_iss_cnt"}, iss_q.size(), N3P);
    check({pfx, "_tag_cnt"}, tag_q.size(), N3P);
    for (int k = 0; k < N3P; k++) begin
      check({pfx, "_iss"}, (k < iss_q.size()) ? iss_q[k] : -1, n3[k][0] * 256 + n3[k][1]);
      check({pfx, "_tag"}, (k < tag_q.size()) ? tag_q[k] : -1,
            tcode(n3[k][0], n3[k][1], n3[k][2], n3[k][3], n3[k][4]));
    end
    check({pfx, "_first_iss_cyc"}, first_iss_cyc, 1);
    check({pfx, "_first_tag_cyc"}, first_tag_cyc, 125);
    check({pfx, "_done_cnt"}, done_cnt, 1);
    check({pfx, "_done_cyc"}, done_cyc, SKIP ? 130 : 133);
    check({pfx, "_done_tag"}, done_tag, SKIP ? tcode(2,1,0,1,0) : tcode(2,2,0,1,1));
    check({pfx, "_busy_at_done"}, busy_at_done, 1);
    check({pfx, "_busy_after_done"}, busy_after_done, 0);
  endtask

  initial begin
    int ntag;
    int ndone;
    rst = 1'b1; start = 1'b0; abort = 1'b0; num_bodies = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_issue_valid", issue_valid, 0);
    check("rst_tag_valid", tag_valid, 0);
    check("rst_rd_i", rd_i, 0);
    check("rst_tag_j", tag_j, 0);
    rst = 1'b0;

    run(3, 0, 0, 400);
    check_n3("n3");

    run(3, 0, 4, 400);
    check_n3("n3_restart");

    run(0, 0, 0, 40);
    check("n0_iss_cnt", iss_q.size(), 0);
    check("n0_tag_cnt", tag_q.size(), 0);
    check("n0_done_cnt", done_cnt, 1);
    check("n0_done_cyc", done_cyc, 1);

    run(1, 0, 0, 300);
    check("n1_iss_cnt", iss_q.size(), SKIP ? 0 : 1);
    check("n1_tag_cnt", tag_q.size(), SKIP ? 0 : 1);
    check("n1_tag", (tag_q.size() > 0) ? tag_q[0] : -1, SKIP ? -1 : tcode(0,0,1,1,1));
    check("n1_done_cnt", done_cnt, 1);
    check("n1_done_cyc", done_cyc, SKIP ? 1 : 125);

    run(4, 7, 0, 200);
    check("abort_iss_cnt", iss_q.size(), 7);
    check("abort_iss7", (iss_q.size() > 6) ? iss_q[6] : -1, SKIP ? 512 : 258);
    check("abort_tag_cnt", tag_q.size(), 0);
    check("abort_done_cnt", done_cnt, 0);
    check("abort_busy_next", busy_after_abort, 0);
    check("abort_iv_next", iv_after_abort, 0);

    run(2, 0, 0, 300);
    check("n2_iss_cnt", iss_q.size(), SKIP ? 2 : 4);
    check("n2_tag_cnt", tag_q.size(), SKIP ? 2 : 4);
    check("n2_tag0", (tag_q.size() > 0) ? tag_q[0] : -1, SKIP ? tcode(0,1,1,1,0) : tcode(0,0,1,0,1));
    check("n2_tag1", (tag_q.size() > 1) ? tag_q[1] : -1, SKIP ? tcode(1,0,1,1,0) : tcode(0,1,0,1,0));
    check("n2_done_cnt", done_cnt, 1);
    check("n2_done_cyc", done_cyc, SKIP ? 126 : 128);
    check("n2_done_tag", done_tag, SKIP ? tcode(1,0,1,1,0) : tcode(1,1,0,1,1));

    // start and abort in the same cycle: abort wins
    @(negedge clk);
    num_bodies = 3; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("sa_busy", busy, 0);
    check("sa_issue_valid", issue_valid, 0);
    check("sa_done", done, 0);

    // reset while the first tag drains
    @(negedge clk);
    num_bodies = 2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (124) @(negedge clk);
    check("rstd_pre_tag_valid", tag_valid, 1);
    check("rstd_pre_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    check("rstd_busy", busy, 0);
    check("rstd_tag_valid", tag_valid, 0);
    check("rstd_tag_first", tag_first, 0);
    check("rstd_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    ntag = 0;
    ndone = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (tag_valid) ntag++;
      if (done) ndone++;
    end
    check("rstd_tags_after", ntag, 0);
    check("rstd_done_after", ndone, 0);

    run(31, 0, 0, 600);
    check("clamp_iss_cnt", iss_q.size(), SKIP ? 240 : 256);
    check("clamp_tag_cnt", tag_q.size(), SKIP ? 240 : 256);
    check("clamp_done_cnt", done_cnt, 1);
    check("clamp_done_cyc", done_cyc, SKIP ? 364 : 380);
    check("clamp_done_tag", done_tag, SKIP ? tcode(15,14,0,1,0) : tcode(15,15,0,1,1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
